// File: rtl/sin_cos_table_arbiter_pkg.sv
// Shared constants and tag type for clients of the fixed-latency sin/cos ROM.
// A tag rides alongside each lookup so the result can be steered back to its requester.
package sin_cos_table_arbiter_pkg;

  localparam int SIN_COS_TABLE_LATENCY = 4;
  localparam int REQ_ID_W              = 1;

  typedef struct packed {
    logic                vld;
    logic [REQ_ID_W-1:0] id;
  } req_tag_t;

  localparam int REQ_TAG_W = $bits(req_tag_t);

  function automatic req_tag_t make_tag(input logic vld, input logic [REQ_ID_W-1:0] id);
    req_tag_t t;
    t.vld = vld;
    t.id  = id;
    return t;
  endfunction

endpackage

// File: rtl/valid_tag_delay.sv
// Fixed-depth shift register with clock enable and async clear.
// Carries {valid,id} tags in step with a fixed-latency ROM pipeline.
module valid_tag_delay #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/sin_cos_table_arbiter.sv
// Round-robin share of one sin_cos_table between two requesters; each lookup is
// tagged on issue and its SIN/COS result is strobed back to the issuing requester.
module sin_cos_table_arbiter
  import sin_cos_table_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 13,
  parameter int TABLE_LATENCY = SIN_COS_TABLE_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  REQ0_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ0_PHASE,
  output logic                  REQ0_READY,
  input  logic                  REQ1_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ1_PHASE,
  output logic                  REQ1_READY,
  output logic                  TABLE_CE,
  output logic [ADDR_WIDTH-1:0] TABLE_PHASE,
  input  logic [DATA_WIDTH-1:0] TABLE_SIN,
  input  logic [DATA_WIDTH-1:0] TABLE_COS,
  output logic                  RES0_VALID,
  output logic                  RES1_VALID,
  output logic [DATA_WIDTH-1:0] RES_SIN,
  output logic [DATA_WIDTH-1:0] RES_COS
);

  if (TABLE_LATENCY < 1) begin : g_bad_latency
    $error("TABLE_LATENCY must be at least 1");
  end

  logic                         rr_last_q;
  logic                         rr_last_d;
  logic        [ADDR_WIDTH-1:0] phase_q;
  logic        [ADDR_WIDTH-1:0] phase_d;
  logic        [1:0]            res_vld_q;
  logic        [1:0]            res_vld_d;
  logic signed [DATA_WIDTH-1:0] res_sin_q;
  logic signed [DATA_WIDTH-1:0] res_sin_d;
  logic signed [DATA_WIDTH-1:0] res_cos_q;
  logic signed [DATA_WIDTH-1:0] res_cos_d;

  logic                 grant_id;
  logic                 xfer;
  req_tag_t             issue_tag;
  req_tag_t             last_tag;
  logic [REQ_TAG_W-1:0] last_tag_bits;

  // Issue stage: arbitration, TABLE_PHASE register and tag entry
  always_comb begin
    grant_id = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      grant_id = ~rr_last_q;
    end else if (REQ1_VALID) begin
      grant_id = 1'b1;
    end
    xfer       = CE & (REQ0_VALID | REQ1_VALID);
    REQ0_READY = CE & REQ0_VALID & ~grant_id;
    REQ1_READY = CE & REQ1_VALID &  grant_id;

    rr_last_d = rr_last_q;
    phase_d   = phase_q;
    issue_tag = make_tag(1'b0, '0);
    if (xfer) begin
      rr_last_d = grant_id;
      phase_d   = grant_id ? REQ1_PHASE : REQ0_PHASE;
      issue_tag = make_tag(1'b1, grant_id);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr_last_q <= 1'b1;
      phase_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      phase_q   <= phase_d;
    end
  end

  // Table stages: one for the phase register plus the ROM latency
  valid_tag_delay #(
    .DEPTH (TABLE_LATENCY + 1),
    .WIDTH (REQ_TAG_W)
  ) u_tag_delay (
    .clk  (CLK),
    .rst  (RESET),
    .ce   (CE),
    .din  (issue_tag),
    .dout (last_tag_bits)
  );

  assign last_tag = req_tag_t'(last_tag_bits);

  // Result stage: strobe flags hold while frozen so a pending result is shown once CE returns
  always_comb begin
    res_vld_d = res_vld_q;
    res_sin_d = res_sin_q;
    res_cos_d = res_cos_q;
    if (CE) begin
      res_vld_d[0] = last_tag.vld & (last_tag.id == 1'b0);
      res_vld_d[1] = last_tag.vld & (last_tag.id == 1'b1);
      if (last_tag.vld) begin
        res_sin_d = TABLE_SIN;
        res_cos_d = TABLE_COS;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      res_vld_q <= '0;
      res_sin_q <= '0;
      res_cos_q <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      res_sin_q <= res_sin_d;
      res_cos_q <= res_cos_d;
    end
  end

  assign TABLE_CE    = CE;
  assign TABLE_PHASE = phase_q;
  assign RES0_VALID  = res_vld_q[0] & CE;
  assign RES1_VALID  = res_vld_q[1] & CE;
  assign RES_SIN     = res_sin_q;
  assign RES_COS     = res_cos_q;

endmodule

// File: tb/tb_sin_cos_table_arbiter.sv
// Directed bench for sin_cos_table_arbiter with a behavioural 4-cycle sin/cos ROM.
module tb_sin_cos_table_arbiter;

  localparam int AW = 12;
  localparam int DW = 13;

  logic          clk;
  logic          rst;
  logic          ce;
  logic          r0v;
  logic          r1v;
  logic [AW-1:0] r0p;
  logic [AW-1:0] r1p;
  logic          rdy0;
  logic          rdy1;
  logic          tce;
  logic [AW-1:0] tph;
  logic [DW-1:0] tsin;
  logic [DW-1:0] tcos;
  logic          v0;
  logic          v1;
  logic [DW-1:0] rsin;
  logic [DW-1:0] rcos;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [DW-1:0] POS_MAX = 13'h0FFF;
  localparam logic [DW-1:0] NEG_MAX = 13'h1001;

  sin_cos_table_arbiter dut (
    .CLK         (clk),
    .RESET       (rst),
    .CE          (ce),
    .REQ0_VALID  (r0v),
    .REQ0_PHASE  (r0p),
    .REQ0_READY  (rdy0),
    .REQ1_VALID  (r1v),
    .REQ1_PHASE  (r1p),
    .REQ1_READY  (rdy1),
    .TABLE_CE    (tce),
    .TABLE_PHASE (tph),
    .TABLE_SIN   (tsin),
    .TABLE_COS   (tcos),
    .RES0_VALID  (v0),
    .RES1_VALID  (v1),
    .RES_SIN     (rsin),
    .RES_COS     (rcos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] sin_ref(input logic [AW-1:0] p);
    real a;
    a = 2.0 * 3.141592653589793 * real'(p) / 4096.0;
    return DW'($rtoi($floor(4095.0 * $sin(a) + 0.5)));
  endfunction

  function automatic logic [DW-1:0] cos_ref(input logic [AW-1:0] p);
    real a;
    a = 2.0 * 3.141592653589793 * real'(p) / 4096.0;
    return DW'($rtoi($floor(4095.0 * $cos(a) + 0.5)));
  endfunction

  // Behavioural ROM: PHASE to SIN/COS in 4 CE-enabled cycles, sync reset
  logic [DW-1:0] ts_q [4];
  logic [DW-1:0] tc_q [4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        ts_q[i] <= '0;
        tc_q[i] <= '0;
      end
    end else if (tce) begin
      ts_q[0] <= sin_ref(tph);
      tc_q[0] <= cos_ref(tph);
      for (int i = 1; i < 4; i++) begin
        ts_q[i] <= ts_q[i-1];
        tc_q[i] <= tc_q[i-1];
      end
    end
  end
  assign tsin = ts_q[3];
  assign tcos = tc_q[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    r0v = 1'b0;
    r1v = 1'b0;
    ce  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    r0v = 1'b0; r1v = 1'b0; r0p = '0; r1p = '0; ce = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({rdy0, rdy1, v0, v1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got rdy0,rdy1,v0,v1=%b want 0000", {rdy0, rdy1, v0, v1});
    end
    n_cmp++;
    if (tph !== '0) begin
      n_bad++;
      $display("FAIL reset_table_phase got %h want 000", tph);
    end
    n_cmp++;
    if (rsin !== '0 || rcos !== '0) begin
      n_bad++;
      $display("FAIL reset_result got sin=%h cos=%h want 0/0", rsin, rcos);
    end
    n_cmp++;
    if (tce !== 1'b1) begin
      n_bad++;
      $display("FAIL table_ce got %b want 1", tce);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    r0v = 1'b1; r0p = 12'h400; r1v = 1'b0;
    #1;
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ready got rdy0=%b rdy1=%b want 1/0", rdy0, rdy1);
    end
    tick();
    r0v = 1'b0;
    n_cmp++;
    if (tph !== 12'h400) begin
      n_bad++;
      $display("FAIL single_table_phase got %h want 400", tph);
    end
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) tick();
      n_cmp++;
      if ({v1, v0} !== ((i == 6) ? 2'b01 : 2'b00)) begin
        n_bad++;
        $display("FAIL single_valid cycle %0d got v1v0=%b want %b", i, {v1, v0}, (i == 6) ? 2'b01 : 2'b00);
      end
      if (i == 6) begin
        n_cmp++;
        if (rsin !== POS_MAX || rcos !== '0) begin
          n_bad++;
          $display("FAIL single_data got sin=%h cos=%h want 0fff/0000", rsin, rcos);
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic e0;
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      r0v = (i < 8); r1v = (i < 8); r0p = 12'h000; r1p = 12'h800;
      #1;
      if (i < 8) begin
        n_cmp++;
        if (rdy0 !== (i % 2 == 0) || rdy1 !== (i % 2 != 0)) begin
          n_bad++;
          $display("FAIL alt_grant cycle %0d got rdy0=%b rdy1=%b want %b/%b", i, rdy0, rdy1, (i % 2 == 0), (i % 2 != 0));
        end
      end
      if (i >= 6 && i < 14) begin
        e0 = ((i - 6) % 2 == 0);
        n_cmp++;
        if ({v1, v0} !== {~e0, e0} || rsin !== '0 || rcos !== (e0 ? POS_MAX : NEG_MAX)) begin
          n_bad++;
          $display("FAIL alt_result cycle %0d got v1v0=%b sin=%h cos=%h want %b 0000 %h", i, {v1, v0}, rsin, rcos, {~e0, e0}, e0 ? POS_MAX : NEG_MAX);
        end
      end else begin
        n_cmp++;
        if ({v1, v0} !== 2'b00) begin
          n_bad++;
          $display("FAIL alt_idle cycle %0d got v1v0=%b want 00", i, {v1, v0});
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] p;
    for (int i = 0; i < 23; i++) begin
      r0v = 1'b0; r1v = (i < 16); r1p = AW'(i);
      #1;
      if (i < 16) begin
        n_cmp++;
        if (rdy1 !== 1'b1 || rdy0 !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_ready cycle %0d got rdy1=%b rdy0=%b want 1/0", i, rdy1, rdy0);
        end
      end
      if (i >= 6 && i < 22) begin
        p = AW'(i - 6);
        n_cmp++;
        if ({v1, v0} !== 2'b10 || rsin !== sin_ref(p) || rcos !== cos_ref(p)) begin
          n_bad++;
          $display("FAIL b2b_result phase %h got v1v0=%b sin=%h cos=%h want 10 %h %h", p, {v1, v0}, rsin, rcos, sin_ref(p), cos_ref(p));
        end
      end else begin
        n_cmp++;
        if ({v1, v0} !== 2'b00) begin
          n_bad++;
          $display("FAIL b2b_idle cycle %0d got v1v0=%b want 00", i, {v1, v0});
        end
      end
      tick();
    end
  endtask

  task automatic test_ce_freeze();
    logic [AW-1:0] p;
    for (int i = 0; i < 13; i++) begin
      ce  = !(i == 3 || i == 4);
      r1v = 1'b0;
      r0v = (i < 5);
      r0p = (i < 3) ? AW'((i + 1) << 8) : 12'h3FF;
      #1;
      n_cmp++;
      if (rdy0 !== (i < 3) || rdy1 !== 1'b0) begin
        n_bad++;
        $display("FAIL ce_ready cycle %0d got rdy0=%b want %b", i, rdy0, (i < 3));
      end
      if (i >= 8 && i <= 10) begin
        p = AW'((i - 7) << 8);
        n_cmp++;
        if ({v1, v0} !== 2'b01 || rsin !== sin_ref(p) || rcos !== cos_ref(p)) begin
          n_bad++;
          $display("FAIL ce_result cycle %0d got v1v0=%b sin=%h cos=%h want 01 %h %h", i, {v1, v0}, rsin, rcos, sin_ref(p), cos_ref(p));
        end
      end else begin
        n_cmp++;
        if ({v1, v0} !== 2'b00) begin
          n_bad++;
          $display("FAIL ce_idle cycle %0d got v1v0=%b want 00", i, {v1, v0});
        end
      end
      tick();
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) begin
      r1v = 1'b1; r1p = AW'(12'h010 + i);
      tick();
    end
    r1v = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({rdy0, rdy1, v0, v1} !== 4'b0000 || tph !== '0 || rsin !== '0 || rcos !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got flags=%b phase=%h sin=%h cos=%h want all 0", {rdy0, rdy1, v0, v1}, tph, rsin, rcos);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick();
      n_cmp++;
      if ({v1, v0} !== 2'b00) begin
        n_bad++;
        $display("FAIL midreset_flush cycle %0d got v1v0=%b want 00", j, {v1, v0});
      end
    end
    r0v = 1'b1; r1v = 1'b1; r0p = 12'h400; r1p = 12'h800;
    #1;
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_first_grant got rdy0=%b rdy1=%b want 1/0", rdy0, rdy1);
    end
    tick();
    r0v = 1'b0; r1v = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) tick();
      n_cmp++;
      if ({v1, v0} !== ((i == 6) ? 2'b01 : 2'b00) || (i == 6 && rsin !== POS_MAX)) begin
        n_bad++;
        $display("FAIL midreset_result cycle %0d got v1v0=%b sin=%h", i, {v1, v0}, rsin);
      end
    end
  endtask

  task automatic test_drop_valid();
    logic [1:0] er;
    logic [1:0] ev;
    for (int i = 0; i < 11; i++) begin
      r0v = (i == 0 || i == 2); r1v = (i == 1 || i == 2); r0p = 12'h400; r1p = 12'h800;
      #1;
      er = (i == 1) ? 2'b10 : ((i == 0 || i == 2) ? 2'b01 : 2'b00);
      n_cmp++;
      if ({rdy1, rdy0} !== er) begin
        n_bad++;
        $display("FAIL drop_ready cycle %0d got rdy1rdy0=%b want %b", i, {rdy1, rdy0}, er);
      end
      ev = (i == 7) ? 2'b10 : ((i == 6 || i == 8) ? 2'b01 : 2'b00);
      n_cmp++;
      if ({v1, v0} !== ev) begin
        n_bad++;
        $display("FAIL drop_result cycle %0d got v1v0=%b want %b", i, {v1, v0}, ev);
      end
      if (ev == 2'b10) begin
        n_cmp++;
        if (rcos !== NEG_MAX || rsin !== '0) begin
          n_bad++;
          $display("FAIL drop_data got sin=%h cos=%h want 0000/1001", rsin, rcos);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; r0v = 1'b0; r1v = 1'b0; r0p = '0; r1p = '0;
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_ce_freeze();
    test_reset_midflight();
    test_drop_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
